// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream and writes
// big-endian 32-bit words into the fetch stage's instruction memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; CPU released
// HDR_HI  | expecting high byte of word count
// HDR_LO  | expecting low byte of word count
// COLLECT | shifting in bytes of the current word, MSB first
// WRITE   | one-cycle write strobe for the assembled word
// DONE    | one-cycle completion pulse
module imem_loader #(
  parameter int IMEM_SIZE = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        hold,
  output logic        done,
  output logic        overflow,
  output logic [15:0] loaded
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    COLLECT = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [16:0] SIZE_L = 17'(IMEM_SIZE);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] loaded_q, loaded_d;
  logic        overflow_q, overflow_d;

  logic        xfer;
  logic        in_range;
  logic [15:0] hdr_n;
  logic [15:0] idx_inc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      loaded_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      loaded_q   <= loaded_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == COLLECT);
    xfer     = in_valid && in_ready;
    in_range = ({1'b0, idx_q} < SIZE_L);
    hdr_n    = {n_q[15:8], in_data};
    idx_inc  = idx_q + 16'd1;
    we       = (state_q == WRITE) && in_range;
    hold     = (state_q != IDLE);
    done     = (state_q == DONE);
    waddr    = waddr_q;
    wdata    = wdata_q;
    overflow = overflow_q;
    loaded   = loaded_q;
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    loaded_d   = loaded_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          loaded_d   = '0;
          overflow_d = 1'b0;
          state_d    = HDR_HI;
        end
      end

      HDR_HI: begin
        if (xfer) begin
          n_d[15:8] = in_data;
          state_d   = HDR_LO;
        end
      end

      HDR_LO: begin
        if (xfer) begin
          n_d    = hdr_n;
          idx_d  = '0;
          bcnt_d = '0;
          if ({1'b0, hdr_n} > SIZE_L) overflow_d = 1'b1;
          state_d = (hdr_n == 16'd0) ? DONE : COLLECT;
        end
      end

      COLLECT: begin
        if (xfer) begin
          shift_d = {shift_q[15:0], in_data};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Latch the address with the word so both stay valid after WRITE.
            wdata_d = {shift_q, in_data};
            waddr_d = {14'd0, idx_q, 2'b00};
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        if (in_range) loaded_d = loaded_q + 16'd1;
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? DONE : COLLECT;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (IMEM_SIZE=4): table of loads checked through a write
// scoreboard, plus hand sequences for mid-word reset and start-while-busy.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        hold;
  logic        done;
  logic        overflow;
  logic [15:0] loaded;

  localparam int SIZE = 4;

  imem_loader #(.IMEM_SIZE(SIZE)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .hold     (hold),
    .done     (done),
    .overflow (overflow),
    .loaded   (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [31:0] words [6];
    int          gap;
    bit          busy_start;
    logic [15:0] exp_loaded;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   vectors;
  int   miscompares;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", waddr, e.addr);
        chk("wdata", wdata, e.data);
      end
      chk("in_ready_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_hold_on"}, {31'd0, hold}, 32'd1);
    chk({tag, "_ready_on"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ovf_clr"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_loaded_clr"}, {16'd0, loaded}, 32'd0);
    send_byte(v.n[15:8], v.gap);
    send_byte(v.n[7:0], v.gap);
    for (int w = 0; w < int'(v.n); w++) begin
      logic [31:0] word;
      word = v.words[w];
      if (w < SIZE) begin
        wr_t e;
        e.addr = 32'(w) * 32'd4;
        e.data = word;
        exp_q.push_back(e);
      end
      send_byte(word[31:24], v.gap);
      send_byte(word[23:16], v.gap);
      if (v.busy_start && w == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(word[15:8], v.gap);
      send_byte(word[7:0], v.gap);
    end
    if (v.n != 16'd0) @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hold_at_done"}, {31'd0, hold}, 32'd1);
    chk({tag, "_loaded"}, {16'd0, loaded}, {16'd0, v.exp_loaded});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold_fall"}, {31'd0, hold}, 32'd0);
    chk({tag, "_ovf_sticky"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    rst_n       = 1'b0;

    tbl[0] = '{16'd2, '{32'hDEADBEEF, 32'h00000001, 0, 0, 0, 0}, 0, 1'b0, 16'd2, 1'b0};
    tbl[1] = '{16'd2, '{32'hDEADBEEF, 32'h00000001, 0, 0, 0, 0}, 3, 1'b0, 16'd2, 1'b0};
    tbl[2] = '{16'd0, '{0, 0, 0, 0, 0, 0}, 0, 1'b0, 16'd0, 1'b0};
    tbl[3] = '{16'd5, '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                        32'h55555555, 0}, 0, 1'b1, 16'd4, 1'b1};
    tbl[4] = '{16'd4, '{32'hA0B0C0D0, 32'h01020304, 32'hFFFFFFFF, 32'h80000001,
                        0, 0}, 1, 1'b0, 16'd4, 1'b0};
    tbl[5] = '{16'd1, '{32'hCAFEF00D, 0, 0, 0, 0, 0}, 2, 1'b0, 16'd1, 1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_waddr", waddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_loaded", {16'd0, loaded}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a word, then a clean reload.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    chk("mid_hold_busy", {31'd0, hold}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hold", {31'd0, hold}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_waddr", waddr, 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    chk("mid_rst_loaded", {16'd0, loaded}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin
      vec_t r;
      r = '{16'd1, '{32'h12345678, 0, 0, 0, 0, 0}, 0, 1'b0, 16'd1, 1'b0};
      run_vec(r, "after_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
